// File: rtl/dst_tracker.sv
// Destination-register tracker for a 5-stage pipeline.
// Carries the write tags of the EX/MEM/WB stages and generates the stall
// for load-use hazards and for draining the pipe after a halt.
module dst_tracker #(
    parameter int         LOAD_STALL = 1,
    parameter logic [3:0] OP_LW      = 4'h8,
    parameter logic [3:0] OP_HLT     = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [3:0] id_opCode,
    input  logic [3:0] id_wrReg,
    input  logic [3:0] id_rdReg1,
    input  logic [3:0] id_rdReg2,
    input  logic       flush,
    output logic [3:0] wrReg_EX,
    output logic [3:0] wrReg_MEM,
    output logic [3:0] wrReg_WB,
    output logic       ex_isLoad,
    output logic       stall,
    output logic       halted
);

    typedef enum logic [1:0] {RUN, LDSTALL, DRAIN, HALTED} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       hazard;
    logic       issue;
    logic [3:0] ex_tag_nxt;
    logic       ex_load_nxt;
    logic       pipe_empty;

    // Register 0 can never match here: wrReg_EX must be non-zero for a hazard.
    assign hazard = ex_isLoad && (wrReg_EX != 4'h0) && id_valid &&
                    ((id_rdReg1 == wrReg_EX) || (id_rdReg2 == wrReg_EX));

    assign pipe_empty = (wrReg_EX == 4'h0) && (wrReg_MEM == 4'h0) && (wrReg_WB == 4'h0);

    // Next-state, bubble counter and stall decode; flush outranks stall in RUN/LDSTALL.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            RUN: begin
                if (hazard && !flush) begin
                    stall   = 1'b1;
                    cnt_nxt = 2'(LOAD_STALL - 1);
                    if (LOAD_STALL > 1) state_nxt = LDSTALL;
                end else if (flush) begin
                    cnt_nxt = 2'd0;
                end else if (id_valid && (id_opCode == OP_HLT)) begin
                    state_nxt = DRAIN;
                end
            end
            LDSTALL: begin
                if (flush) begin
                    cnt_nxt   = 2'd0;
                    state_nxt = RUN;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = RUN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (pipe_empty) state_nxt = HALTED;
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Tag entering EX: the ID instruction only when it actually issues; HLT writes nothing.
    always_comb begin
        issue       = id_valid && !flush && !stall;
        ex_tag_nxt  = (issue && (id_opCode != OP_HLT)) ? id_wrReg : 4'h0;
        ex_load_nxt = issue && (id_opCode == OP_LW);
    end

    // State register and tag shift; tags freeze once halted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= 2'd0;
            halted    <= 1'b0;
            wrReg_EX  <= 4'h0;
            wrReg_MEM <= 4'h0;
            wrReg_WB  <= 4'h0;
            ex_isLoad <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            halted <= (state_nxt == HALTED);
            if (state != HALTED) begin
                wrReg_WB  <= wrReg_MEM;
                wrReg_MEM <= wrReg_EX;
                wrReg_EX  <= ex_tag_nxt;
                ex_isLoad <= ex_load_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dst_tracker.sv
// Bench for dst_tracker: two instances (LOAD_STALL = 1 and 3) share the
// stimulus and are each compared against a behavioural pipeline model.
module tb_dst_tracker;

    localparam logic [3:0] LW  = 4'h8;
    localparam logic [3:0] HLT = 4'hF;
    localparam logic [3:0] ADD = 4'h0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_opCode, id_wrReg, id_rdReg1, id_rdReg2;
    logic       flush;

    logic [3:0] o_ex[2], o_mem[2], o_wb[2];
    logic       o_ld[2], o_stall[2], o_halt[2];

    int checks = 0;
    int errors = 0;

    // model state per instance
    int m_ex[2], m_mem[2], m_wb[2], m_load[2], m_left[2], m_drain[2], m_halt[2];
    logic seen_stall[2];
    logic last_es;

    always #5 clk = ~clk;

    dst_tracker #(.LOAD_STALL(1), .OP_LW(LW), .OP_HLT(HLT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opCode(id_opCode),
        .id_wrReg(id_wrReg), .id_rdReg1(id_rdReg1), .id_rdReg2(id_rdReg2), .flush(flush),
        .wrReg_EX(o_ex[0]), .wrReg_MEM(o_mem[0]), .wrReg_WB(o_wb[0]),
        .ex_isLoad(o_ld[0]), .stall(o_stall[0]), .halted(o_halt[0]));

    dst_tracker #(.LOAD_STALL(3), .OP_LW(LW), .OP_HLT(HLT)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opCode(id_opCode),
        .id_wrReg(id_wrReg), .id_rdReg1(id_rdReg1), .id_rdReg2(id_rdReg2), .flush(flush),
        .wrReg_EX(o_ex[1]), .wrReg_MEM(o_mem[1]), .wrReg_WB(o_wb[1]),
        .ex_isLoad(o_ld[1]), .stall(o_stall[1]), .halted(o_halt[1]));

    function automatic int ls(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = 0; m_mem[k] = 0; m_wb[k] = 0; m_load[k] = 0;
            m_left[k] = 0; m_drain[k] = 0; m_halt[k] = 0;
        end
        last_es = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; id_valid = 1'b0; id_opCode = 4'h0; id_wrReg = 4'h0;
        id_rdReg1 = 4'h0; id_rdReg2 = 4'h0; flush = 1'b0;
        repeat (n) @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // One cycle: drive ID, check all outputs mid-cycle, advance the model at the edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] wr,
                        input logic [3:0] r1, input logic [3:0] r2, input logic fl);
        int es[2];
        id_valid = v; id_opCode = op; id_wrReg = wr; id_rdReg1 = r1; id_rdReg2 = r2; flush = fl;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (m_drain[k] != 0 || m_halt[k] != 0) es[k] = 1;
            else if (m_left[k] > 0) es[k] = fl ? 0 : 1;
            else es[k] = (m_load[k] != 0 && m_ex[k] != 0 && v &&
                          (int'(r1) == m_ex[k] || int'(r2) == m_ex[k]) && !fl) ? 1 : 0;
            seen_stall[k] = o_stall[k];
            checks += 6;
            if (o_stall[k] !== es[k][0]) begin
                errors++; $display("FAIL stall[%0d] t=%0t got %b want %0d", k, $time, o_stall[k], es[k]);
            end
            if (o_ex[k] !== 4'(m_ex[k])) begin
                errors++; $display("FAIL wrReg_EX[%0d] t=%0t got %0d want %0d", k, $time, o_ex[k], m_ex[k]);
            end
            if (o_mem[k] !== 4'(m_mem[k])) begin
                errors++; $display("FAIL wrReg_MEM[%0d] t=%0t got %0d want %0d", k, $time, o_mem[k], m_mem[k]);
            end
            if (o_wb[k] !== 4'(m_wb[k])) begin
                errors++; $display("FAIL wrReg_WB[%0d] t=%0t got %0d want %0d", k, $time, o_wb[k], m_wb[k]);
            end
            if (o_ld[k] !== m_load[k][0]) begin
                errors++; $display("FAIL ex_isLoad[%0d] t=%0t got %b want %0d", k, $time, o_ld[k], m_load[k]);
            end
            if (o_halt[k] !== m_halt[k][0]) begin
                errors++; $display("FAIL halted[%0d] t=%0t got %b want %0d", k, $time, o_halt[k], m_halt[k]);
            end
        end
        last_es = es[0][0];
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (m_halt[k] == 0) begin
                bit empty, iss;
                empty = (m_ex[k] == 0 && m_mem[k] == 0 && m_wb[k] == 0);
                iss   = v && !fl && es[k] == 0;
                m_wb[k]   = m_mem[k];
                m_mem[k]  = m_ex[k];
                m_ex[k]   = (iss && op != HLT) ? int'(wr) : 0;
                m_load[k] = (iss && op == LW) ? 1 : 0;
                if (m_drain[k] != 0) begin
                    if (empty) m_halt[k] = 1;
                end else if (fl) m_left[k] = 0;
                else if (m_left[k] > 0) m_left[k]--;
                else if (es[k] != 0) m_left[k] = ls(k) - 1;
                else if (iss && op == HLT) m_drain[k] = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, ADD, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(2);
        idle(1);
        checks++;
        if (seen_stall[0] !== 1'b0 || seen_stall[1] !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b%b want 00", seen_stall[0], seen_stall[1]);
        end
    endtask

    task automatic test_back_to_back();
        step(1, ADD, 4'd3, 4'd1, 4'd2, 0);
        step(1, ADD, 4'd5, 4'd1, 4'd2, 0);
        step(1, ADD, 4'd7, 4'd1, 4'd2, 0);
        checks++;
        if (o_ex[0] !== 4'd7 || o_mem[0] !== 4'd5 || o_wb[0] !== 4'd3) begin
            errors++; $display("FAIL b2b_tags got %0d/%0d/%0d want 7/5/3", o_ex[0], o_mem[0], o_wb[0]);
        end
        idle(3);
    endtask

    task automatic test_load_use();
        step(1, LW,  4'd4, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd9, 4'd4, 4'd2, 0);
        checks += 2;
        if (seen_stall[0] !== 1'b1) begin
            errors++; $display("FAIL ldu_stall got %b want 1", seen_stall[0]);
        end
        if (o_ex[0] !== 4'd0) begin
            errors++; $display("FAIL ldu_bubble got %0d want 0", o_ex[0]);
        end
        step(1, ADD, 4'd9, 4'd4, 4'd2, 0);
        checks += 2;
        if (seen_stall[0] !== 1'b0) begin
            errors++; $display("FAIL ldu_release got %b want 0", seen_stall[0]);
        end
        if (o_ex[0] !== 4'd9) begin
            errors++; $display("FAIL ldu_issue got %0d want 9", o_ex[0]);
        end
        idle(5);
    endtask

    task automatic test_no_hazard();
        step(1, LW,  4'd0, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd2, 4'd0, 4'd0, 0);
        checks++;
        if (seen_stall[0] !== 1'b0 || seen_stall[1] !== 1'b0) begin
            errors++; $display("FAIL r0_nostall got %b%b want 00", seen_stall[0], seen_stall[1]);
        end
        step(1, LW,  4'd4, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd2, 4'd5, 4'd5, 0);
        checks++;
        if (seen_stall[0] !== 1'b0 || seen_stall[1] !== 1'b0) begin
            errors++; $display("FAIL r5_nostall got %b%b want 00", seen_stall[0], seen_stall[1]);
        end
        idle(3);
    endtask

    task automatic test_flush();
        step(1, LW,  4'd4, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd6, 4'd4, 4'd4, 1);
        checks += 2;
        if (seen_stall[0] !== 1'b0 || seen_stall[1] !== 1'b0) begin
            errors++; $display("FAIL flush_stall got %b%b want 00", seen_stall[0], seen_stall[1]);
        end
        if (o_ex[0] !== 4'd0 || o_ex[1] !== 4'd0) begin
            errors++; $display("FAIL flush_bubble got %0d/%0d want 0/0", o_ex[0], o_ex[1]);
        end
        // flush arriving in the middle of the longer stall
        step(1, LW,  4'd3, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd6, 4'd3, 4'd0, 0);
        step(1, ADD, 4'd6, 4'd3, 4'd0, 1);
        idle(4);
    endtask

    task automatic test_random();
        logic       v, fl;
        logic [3:0] op, wr, r1, r2;
        v = 0; fl = 0; op = 0; wr = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!last_es || fl) begin
                v  = ($urandom_range(0, 9) < 8);
                op = 4'($urandom_range(0, 14));
                if ($urandom_range(0, 2) == 0) op = LW;
                wr = 4'($urandom_range(0, 7));
                r1 = 4'($urandom_range(0, 7));
                r2 = 4'($urandom_range(0, 7));
            end
            fl = ($urandom_range(0, 9) == 0);
            step(v, op, wr, r1, r2, fl);
        end
        idle(5);
    endtask

    task automatic test_reset_ldstall();
        step(1, LW,  4'd4, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd6, 4'd4, 4'd0, 0);
        step(1, ADD, 4'd6, 4'd4, 4'd0, 0);
        checks++;
        if (seen_stall[1] !== 1'b1) begin
            errors++; $display("FAIL ldstall3_mid got %b want 1", seen_stall[1]);
        end
        do_reset(1);
        idle(1);
        checks++;
        if (seen_stall[1] !== 1'b0 || o_halt[1] !== 1'b0 || o_ex[1] !== 4'd0) begin
            errors++; $display("FAIL rst_ldstall got stall=%b halted=%b ex=%0d want 0/0/0",
                               seen_stall[1], o_halt[1], o_ex[1]);
        end
        idle(2);
    endtask

    task automatic test_halt();
        int n;
        step(1, ADD, 4'd2, 4'd1, 4'd0, 0);
        step(1, ADD, 4'd6, 4'd1, 4'd0, 0);
        step(1, HLT, 4'd0, 4'd0, 4'd0, 0);
        n = 0;
        while (o_halt[0] !== 1'b1 && n < 10) begin
            step(1, ADD, 4'd5, 4'd1, 4'd1, (n == 1));
            n++;
        end
        checks += 2;
        if (n != 3) begin
            errors++; $display("FAIL halt_latency got %0d want 3", n);
        end
        if (seen_stall[0] !== 1'b1) begin
            errors++; $display("FAIL drain_stall got %b want 1", seen_stall[0]);
        end
        step(1, ADD, 4'd5, 4'd1, 4'd1, 1);
        step(1, LW,  4'd5, 4'd1, 4'd1, 0);
        checks++;
        if (seen_stall[0] !== 1'b1 || o_halt[0] !== 1'b1 || o_ex[0] !== 4'd0) begin
            errors++; $display("FAIL halted_hold got stall=%b halted=%b ex=%0d want 1/1/0",
                               seen_stall[0], o_halt[0], o_ex[0]);
        end
    endtask

    task automatic test_reset_drain();
        do_reset(1);
        step(1, ADD, 4'd2, 4'd1, 4'd0, 0);
        step(1, HLT, 4'd0, 4'd0, 4'd0, 0);
        step(0, ADD, 4'd0, 4'd0, 4'd0, 0);
        do_reset(1);
        idle(1);
        checks++;
        if (seen_stall[0] !== 1'b0 || o_halt[0] !== 1'b0) begin
            errors++; $display("FAIL rst_drain got stall=%b halted=%b want 0/0", seen_stall[0], o_halt[0]);
        end
        step(1, ADD, 4'd8, 4'd1, 4'd0, 0);
        checks++;
        if (o_ex[0] !== 4'd8) begin
            errors++; $display("FAIL post_rst_issue got %0d want 8", o_ex[0]);
        end
        idle(3);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_random();
        test_reset_ldstall();
        test_halt();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dst_tracker.md
DST_TRACKER -- requirements
Module: dst_tracker

Interface
REQ-001 Parameter LOAD_STALL, default 1, number of bubble cycles inserted for a load-use hazard (legal 1..3).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_opCode  input  4  ID-stage opcode (codes from defines.v).
REQ-006 id_wrReg  input  4  ID-stage destination register; 4'h0 = no write.
REQ-007 id_rdReg1 / id_rdReg2  input  4 each  ID-stage source registers; 4'h0 = unused.
REQ-008 flush  input  1  branch/jump taken in EX; discard the ID instruction.
REQ-009 wrReg_EX / wrReg_MEM / wrReg_WB  output  4 each  destination tags of EX, MEM, WB stages; 4'h0 = bubble/no write.
REQ-010 ex_isLoad  output  1  EX-stage instruction is `LW.
REQ-011 stall  output  1  hold PC and IF/ID registers this cycle.
REQ-012 halted  output  1  pipeline fully drained after `HLT.

Function
REQ-013 Pipeline advance, per cycle, when not halted: wrReg_WB <= wrReg_MEM; wrReg_MEM <= wrReg_EX; wrReg_EX <= next EX tag (REQ-014..016).
REQ-014 Next EX tag = id_wrReg and ex_isLoad <= (id_opCode == `LW) when id_valid, !flush, !stall; otherwise 4'h0 and ex_isLoad <= 0.
REQ-015 Load-use hazard (combinational): ex_isLoad && wrReg_EX != 4'h0 && id_valid && (id_rdReg1 == wrReg_EX || id_rdReg2 == wrReg_EX); register 0 never causes a hazard.
REQ-016 FSM states RUN, LDSTALL, DRAIN, HALTED; reset state RUN.
REQ-017 RUN: on hazard and !flush, stall = 1 in the same cycle, load bubble counter with LOAD_STALL-1; go to LDSTALL if LOAD_STALL > 1, else stay RUN.
REQ-018 LDSTALL: stall = 1 and EX receives bubble each cycle; counter decrements; return to RUN on the cycle counter reaches 0.
REQ-019 flush has priority over stall: flush = 1 forces stall = 0, EX bubble, counter cleared, state RUN.
REQ-020 RUN: id_valid && id_opCode == `HLT && !flush && !stall -> DRAIN; the HLT's tag (4'h0) enters EX; stall = 1 from the next cycle onward.
REQ-021 DRAIN: stall = 1; EX receives bubbles; when wrReg_EX, wrReg_MEM, wrReg_WB are all 4'h0 -> HALTED.
REQ-022 HALTED: stall = 1, halted = 1, all tags held at 4'h0; exit only by reset.
REQ-023 flush in DRAIN or HALTED is ignored.
REQ-024 `LLB, `JAL, `B treated like any other opcode; only id_wrReg/id_rdReg* determine tracking.
REQ-025 stall is the only combinational output; all others are registered.

Reset
REQ-026 While rst_n = 0 at a clock edge: wrReg_EX/MEM/WB = 4'h0, ex_isLoad = 0, halted = 0, counter = 0, state RUN; stall = 0 on the following cycle.
REQ-027 Reset mid-LDSTALL or mid-DRAIN abandons the operation with no residual stall.

Verification
REQ-028 Back-to-back ALU writes r3, r5, r7 with no hazards -> wrReg_EX/MEM/WB = 7/5/3 on cycle 3, stall never asserted.
REQ-029 LW r4 then ADD reading r4 (LOAD_STALL=1) -> stall = 1 for exactly one cycle, wrReg_EX = 0 that next cycle, ADD's tag reaches EX one cycle later.
REQ-030 LW r0 then ADD reading r0 -> no stall; LW r4 then ADD reading only r5 -> no stall.
REQ-031 Load-use hazard with flush = 1 in the same cycle -> stall = 0, wrReg_EX = 0 next cycle.
REQ-032 HLT after writes to r2, r6 -> DRAIN, halted = 1 once all three tags are 0 (3 cycles after HLT reaches EX), stall held at 1.
REQ-033 rst_n = 0 during LDSTALL with LOAD_STALL=3 -> next cycle all tags 0, stall = 0, halted = 0.
